// File: rtl/vliw_stall_flush_ctrl.sv
// vliw_stall_flush_ctrl: merges hazard requests into pipeline enables, sequences flushes, watchdog and stats
module vliw_stall_flush_ctrl #(
  parameter int unsigned FLUSH_CYCLES    = 1,
  parameter int unsigned MAX_STALL       = 64,
  parameter bit          HALT_ON_TIMEOUT = 1'b1,
  parameter int unsigned CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             loadUseStall,
  input  logic             branchDataStall,
  input  logic             branchTaken,
  input  logic             jumpInstr,
  input  logic             memBusy,
  input  logic             clrStats,
  output logic             pcWrite,
  output logic             IFIDwrite,
  output logic             IFID_flush,
  output logic             IDEX_bubble,
  output logic             pipeFreeze,
  output logic [1:0]       pcSrc,
  output logic             hazardTimeout,
  output logic [CNT_W-1:0] stallCount,
  output logic [CNT_W-1:0] flushCount
);
  typedef enum logic [1:0] {RUN, FLUSH, HALT} state_t;
  state_t           state_q, state_d;
  logic             pend_q, pend_d, pend_jmp_q, pend_jmp_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic [15:0]      wd_q, wd_d;
  logic [16:0]      wd_inc;
  logic             to_q, to_d;
  logic [CNT_W-1:0] scnt_q, scnt_d, flcnt_q, flcnt_d;
  logic             halt, hold, fire, redir, take_jmp, flush_take;
  assign halt     = state_q == HALT;
  assign hold     = halt | memBusy | (state_q == RUN && (loadUseStall | branchDataStall));
  assign redir    = branchTaken | jumpInstr;
  assign take_jmp = pend_q ? pend_jmp_q : jumpInstr;
  assign wd_inc   = {1'b0, wd_q} + 17'd1;
  assign fire     = hold && !halt && !clrStats && wd_inc == 17'(MAX_STALL);
  // pipeline enables and next state; freeze beats stall beats redirect
  always_comb begin
    pcWrite     = 1'b1;
    IFIDwrite   = 1'b1;
    IFID_flush  = 1'b0;
    IDEX_bubble = 1'b0;
    pipeFreeze  = 1'b0;
    pcSrc       = 2'b00;
    state_d     = state_q;
    pend_d      = pend_q;
    pend_jmp_d  = pend_jmp_q;
    fcnt_d      = fcnt_q;
    flush_take  = 1'b0;
    if (halt) begin
      pcWrite    = 1'b0;
      IFIDwrite  = 1'b0;
      pipeFreeze = 1'b1;
      if (clrStats) begin
        state_d    = RUN;
        pend_d     = 1'b0;
        pend_jmp_d = 1'b0;
      end
    end else if (memBusy) begin
      pcWrite    = 1'b0;
      IFIDwrite  = 1'b0;
      pipeFreeze = 1'b1;
      if (state_q == RUN && redir && !pend_q) begin
        pend_d     = 1'b1;
        pend_jmp_d = jumpInstr;
      end
    end else if (state_q == FLUSH) begin
      IFID_flush = 1'b1;
      fcnt_d     = fcnt_q - 3'd1;
      if (fcnt_q <= 3'd1) state_d = RUN;
    end else if (loadUseStall | branchDataStall) begin
      pcWrite     = 1'b0;
      IFIDwrite   = 1'b0;
      IDEX_bubble = 1'b1;
    end else if (pend_q | redir) begin
      IFID_flush = 1'b1;
      pcSrc      = take_jmp ? 2'b10 : 2'b01;
      flush_take = 1'b1;
      pend_d     = 1'b0;
      pend_jmp_d = 1'b0;
      if (FLUSH_CYCLES > 1) begin
        state_d = FLUSH;
        fcnt_d  = 3'(FLUSH_CYCLES - 1);
      end
    end
    if (fire && HALT_ON_TIMEOUT) state_d = HALT;
  end
  // watchdog, sticky timeout and saturating statistics; clear wins over increment
  always_comb begin
    wd_d    = (clrStats || !hold) ? '0 : (&wd_q ? wd_q : wd_inc[15:0]);
    to_d    = !clrStats && (to_q || fire);
    scnt_d  = clrStats ? '0 : (hold && !halt && !(&scnt_q)) ? scnt_q + CNT_W'(1) : scnt_q;
    flcnt_d = clrStats ? '0 : (flush_take && !(&flcnt_q)) ? flcnt_q + CNT_W'(1) : flcnt_q;
  end
  // state and bookkeeping registers; reset drops any pending flush or redirect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= RUN;
      pend_q     <= 1'b0;
      pend_jmp_q <= 1'b0;
      fcnt_q     <= '0;
      wd_q       <= '0;
      to_q       <= 1'b0;
      scnt_q     <= '0;
      flcnt_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      pend_jmp_q <= pend_jmp_d;
      fcnt_q     <= fcnt_d;
      wd_q       <= wd_d;
      to_q       <= to_d;
      scnt_q     <= scnt_d;
      flcnt_q    <= flcnt_d;
    end
  end
  assign hazardTimeout = to_q;
  assign stallCount    = scnt_q;
  assign flushCount    = flcnt_q;
endmodule

// File: tb/tb_vliw_stall_flush_ctrl.sv
// tb_vliw_stall_flush_ctrl: scoreboard bench for the stall/flush controller
module tb_vliw_stall_flush_ctrl;
  localparam int CW = 4;
  localparam logic [6:0] NORM = 7'b1100000;
  localparam logic [6:0] STL  = 7'b0001000;
  localparam logic [6:0] FRZ  = 7'b0000100;
  localparam logic [6:0] BR   = 7'b1110001;
  localparam logic [6:0] JP   = 7'b1110010;
  localparam logic [6:0] FL   = 7'b1110000;
  localparam logic [5:0] I_0  = 6'b000000;
  localparam logic [5:0] I_LU = 6'b100000;
  localparam logic [5:0] I_BD = 6'b010000;
  localparam logic [5:0] I_BT = 6'b001000;
  localparam logic [5:0] I_JP = 6'b000100;
  localparam logic [5:0] I_MB = 6'b000010;
  localparam logic [5:0] I_CL = 6'b000001;
  logic clk = 1'b0, rst_n = 1'b0;
  logic loadUseStall = 0, branchDataStall = 0, branchTaken = 0, jumpInstr = 0, memBusy = 0, clrStats = 0;
  logic pcWrite, IFIDwrite, IFID_flush, IDEX_bubble, pipeFreeze, hazardTimeout;
  logic [1:0] pcSrc;
  logic [CW-1:0] stallCount, flushCount;
  logic [6:0] obs, e, a;
  logic [6:0] exp_q[$];
  logic [6:0] act_q[$];
  int checks = 0, errors = 0;
  assign obs = {pcWrite, IFIDwrite, IFID_flush, IDEX_bubble, pipeFreeze, pcSrc};
  always #5 clk = ~clk;
  vliw_stall_flush_ctrl #(.FLUSH_CYCLES(3), .MAX_STALL(8), .HALT_ON_TIMEOUT(1'b1), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .loadUseStall(loadUseStall), .branchDataStall(branchDataStall),
    .branchTaken(branchTaken), .jumpInstr(jumpInstr), .memBusy(memBusy), .clrStats(clrStats),
    .pcWrite(pcWrite), .IFIDwrite(IFIDwrite), .IFID_flush(IFID_flush), .IDEX_bubble(IDEX_bubble),
    .pipeFreeze(pipeFreeze), .pcSrc(pcSrc), .hazardTimeout(hazardTimeout),
    .stallCount(stallCount), .flushCount(flushCount));
  task automatic drive(input logic [5:0] in, input logic [6:0] ex);
    @(negedge clk);
    {loadUseStall, branchDataStall, branchTaken, jumpInstr, memBusy, clrStats} = in;
    exp_q.push_back(ex);
    #1;
    act_q.push_back(obs);
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (obs !== NORM || stallCount !== '0 || flushCount !== '0 || hazardTimeout !== 1'b0) begin
      errors++; $display("FAIL reset_values: got outs=%b st=%0d fl=%0d to=%b, want outs=%b 0 0 0", obs, stallCount, flushCount, hazardTimeout, NORM);
    end
    rst_n = 1'b1;
    drive(I_0, NORM);
    drive(I_BT, BR);
    @(negedge clk);
    {loadUseStall, branchDataStall, branchTaken, jumpInstr, memBusy, clrStats} = I_0;
    #1;
    checks++;
    if (obs !== FL) begin errors++; $display("FAIL pre_reset_flush: got %b want %b", obs, FL); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== NORM || flushCount !== '0) begin
      errors++; $display("FAIL reset_mid_flush: got outs=%b fl=%0d want outs=%b fl=0", obs, flushCount, NORM);
    end
    rst_n = 1'b1;
    drive(I_0, NORM);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL reset_seq: got %b want %b", a, e); end
    end
  endtask
  task automatic test_flush;
    drive(I_CL, NORM);
    drive(I_BT, BR);
    drive(I_BT, FL);
    drive(I_0, FL);
    drive(I_JP, JP);
    drive(I_0, FL);
    drive(I_0, FL);
    drive(I_0, NORM);
    checks++;
    if (flushCount !== 4'd2) begin errors++; $display("FAIL flush_count: got %0d want 2", flushCount); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL flush_seq: got %b want %b", a, e); end
    end
  endtask
  task automatic test_stall_priority;
    drive(I_CL, NORM);
    drive(I_LU | I_JP, STL);
    drive(I_LU | I_JP, STL);
    drive(I_0, NORM);
    checks++;
    if (stallCount !== 4'd2 || flushCount !== 4'd0) begin
      errors++; $display("FAIL stall_counts: got st=%0d fl=%0d want st=2 fl=0", stallCount, flushCount);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL stall_seq: got %b want %b", a, e); end
    end
  endtask
  task automatic test_mem_freeze;
    drive(I_CL, NORM);
    drive(I_MB, FRZ);
    drive(I_MB | I_JP, FRZ);
    drive(I_MB, FRZ);
    drive(I_MB, FRZ);
    drive(I_0, JP);
    drive(I_0, FL);
    drive(I_0, FL);
    drive(I_0, NORM);
    checks++;
    if (stallCount !== 4'd4 || flushCount !== 4'd1) begin
      errors++; $display("FAIL freeze_counts: got st=%0d fl=%0d want st=4 fl=1", stallCount, flushCount);
    end
    drive(I_MB | I_JP, FRZ);
    drive(I_BT, JP);
    drive(I_BT, FL);
    drive(I_0, FL);
    drive(I_0, NORM);
    checks++;
    if (stallCount !== 4'd5 || flushCount !== 4'd2) begin
      errors++; $display("FAIL pending_counts: got st=%0d fl=%0d want st=5 fl=2", stallCount, flushCount);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL freeze_seq: got %b want %b", a, e); end
    end
  endtask
  task automatic test_watchdog;
    drive(I_CL, NORM);
    for (int i = 0; i < 8; i++) drive(I_BD, STL);
    checks++;
    if (hazardTimeout !== 1'b0) begin errors++; $display("FAIL timeout_early: got %b want 0", hazardTimeout); end
    drive(I_0, FRZ);
    checks++;
    if (hazardTimeout !== 1'b1 || stallCount !== 4'd8) begin
      errors++; $display("FAIL timeout_set: got to=%b st=%0d want to=1 st=8", hazardTimeout, stallCount);
    end
    drive(I_BT, FRZ);
    drive(I_CL, FRZ);
    checks++;
    if (stallCount !== 4'd8) begin errors++; $display("FAIL halt_no_count: got %0d want 8", stallCount); end
    drive(I_0, NORM);
    checks++;
    if (hazardTimeout !== 1'b0 || stallCount !== '0 || flushCount !== '0) begin
      errors++; $display("FAIL clr_from_halt: got to=%b st=%0d fl=%0d want 0 0 0", hazardTimeout, stallCount, flushCount);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL watchdog_seq: got %b want %b", a, e); end
    end
  endtask
  task automatic test_saturate;
    drive(I_CL, NORM);
    for (int i = 0; i < 7; i++) drive(I_LU, STL);
    drive(I_0, NORM);
    for (int i = 0; i < 7; i++) drive(I_BD, STL);
    drive(I_0, NORM);
    checks++;
    if (stallCount !== 4'hE) begin errors++; $display("FAIL sat_pre: got %0d want 14", stallCount); end
    for (int i = 0; i < 3; i++) drive(I_LU, STL);
    drive(I_0, NORM);
    checks++;
    if (stallCount !== 4'hF || hazardTimeout !== 1'b0) begin
      errors++; $display("FAIL sat_hold: got st=%0d to=%b want st=15 to=0", stallCount, hazardTimeout);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = act_q.pop_front(); checks++;
      if (a !== e) begin errors++; $display("FAIL sat_seq: got %b want %b", a, e); end
    end
  endtask
  initial begin
    test_reset;
    test_flush;
    test_stall_priority;
    test_mem_freeze;
    test_watchdog;
    test_saturate;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vliw_stall_flush_ctrl.md
Name: vliw_stall_flush_ctrl

Overview:
- Central pipeline controller for the dual-slot (16-bit + 32-bit) VLIW core.
- Merges the per-hazard requests into one consistent set of pipeline enables: load-use stall, branch-data stall, branch/jump redirect and data-memory busy.
- Drives PC write, IF/ID write/flush, ID/EX bubble and PC source.
- Sequences multi-cycle flushes, holds redirects arriving during a memory freeze, and runs a stall watchdog plus saturating event counters.

Parameters:
- FLUSH_CYCLES, 1, number of consecutive IF/ID flush cycles per redirect (1..7).
- MAX_STALL, 64, consecutive stall/freeze cycles before the watchdog fires (2..65535).
- HALT_ON_TIMEOUT, 1, 1 = enter HALT on watchdog, 0 = flag only.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- loadUseStall  in  1  load-use stall request (ID stage)
- branchDataStall  in  1  branch operand-not-ready stall request
- branchTaken  in  1  branch comparator taken and branch instr in ID
- jumpInstr  in  1  jump in ID
- memBusy  in  1  data memory multi-cycle access in progress
- clrStats  in  1  synchronous clear of counters and timeout flag
- pcWrite  out  1  PC register enable
- IFIDwrite  out  1  IF/ID register enable
- IFID_flush  out  1  IF/ID clear to NOP
- IDEX_bubble  out  1  zero ID/EX control signals
- pipeFreeze  out  1  hold ID/EX, EX/MEM, MEM/WB
- pcSrc  out  2  00 PC+4, 01 branch target, 10 jump target
- hazardTimeout  out  1  sticky watchdog flag
- stallCount  out  CNT_W  saturating count of stall/freeze cycles
- flushCount  out  CNT_W  saturating count of redirects taken

Behaviour:
- Reset (async, rst_n=0) values:
  - state=RUN, pending redirect cleared, all counters 0, hazardTimeout=0.
  - pcWrite=1, IFIDwrite=1; all other outputs 0, pcSrc=00.
  - Reset mid-flush or mid-freeze discards all pending work.
- States: RUN, FLUSH, HALT.
- Control outputs are combinational from the current state, the pending register and the current inputs, so stalls act in the same cycle.
- Priority in RUN, highest first:
  1. memBusy: pcWrite=0, IFIDwrite=0, pipeFreeze=1, IDEX_bubble=0.
     - A redirect request (branchTaken|jumpInstr) in this cycle is latched into the pending register with its type. Jump wins if both are set.
     - Flush and pcSrc stay inactive.
  2. loadUseStall|branchDataStall: pcWrite=0, IFIDwrite=0, IDEX_bubble=1.
     - Redirect inputs are ignored, since the branch is unresolved.
  3. Redirect, from the pending register or the inputs (pending first): pcSrc=10 for jump, else 01; pcWrite=1; IFID_flush=1.
     - flushCount increments and pending clears.
     - If FLUSH_CYCLES>1, go to FLUSH with a down-counter loaded to FLUSH_CYCLES-1.
  4. Otherwise: pcWrite=1, IFIDwrite=1, everything else 0.
- FLUSH:
  - IFID_flush=1, pcSrc=00, pcWrite=1.
  - Counter decrements each cycle; return to RUN when it reaches 0.
  - memBusy in FLUSH: freeze as above and hold the counter.
  - New redirects in FLUSH are ignored, because the IDs are flushed.
- Watchdog:
  - Counts consecutive cycles with pcWrite=0.
  - Clears on any cycle with pcWrite=1.
  - On reaching MAX_STALL: set hazardTimeout (sticky). If HALT_ON_TIMEOUT, go to HALT.
- HALT:
  - pcWrite=0, IFIDwrite=0, pipeFreeze=1.
  - Exit only by reset or clrStats; clrStats returns the block to RUN with the pending register cleared.
- Counters:
  - stallCount increments every cycle with pcWrite=0 outside HALT; flushCount increments per redirect.
  - Both saturate at all-ones with no wrap.
  - clrStats zeroes both and the watchdog counter. If clrStats coincides with an increment, the result is 0.
- Simultaneous memBusy deassert and a new redirect input with pending set: the pending redirect is served and the new one is dropped.

Test Plan:
- Reset with rst_n=0 while in FLUSH with counter=2 -> next cycle: pcWrite=1, IFIDwrite=1, IFID_flush=0, pcSrc=00, counters 0.
- FLUSH_CYCLES=3, branchTaken 1 cycle -> IFID_flush=1 for 3 cycles; pcSrc=01 in the first cycle only; flushCount=1.
- loadUseStall=1 and jumpInstr=1 together for 2 cycles -> pcWrite=0, IDEX_bubble=1, pcSrc=00 both cycles; stallCount=2; flushCount=0.
- memBusy=1 for 4 cycles with jumpInstr pulsed in cycle 2 -> pipeFreeze=1 for 4 cycles; first cycle after: pcSrc=10, IFID_flush=1.
- MAX_STALL=8, HALT_ON_TIMEOUT=1, branchDataStall held -> hazardTimeout=1 after 8 cycles; HALT holds; clrStats -> RUN, counters 0.
- Counters at 0xFFFE with 3 more stall cycles -> stallCount stays at 0xFFFF.
